mem_bridge: RTL and testbench

- Sits directly downstream of the multi-cycle CPU core's memory port.
- Consumes the core's mem_init strobe, read/write op codes, address and store data.
- Runs one word-wide request/acknowledge transaction on the system bus, with byte enables and lane steering.
- Returns aligned, sign- or zero-extended load data to the core with a one-cycle mem_ready pulse; a watchdog guarantees the core never hangs.

---
 rtl/mem_ops_pkg.sv | 59 +++++
 rtl/mem_bridge_if.sv | 13 +
 rtl/mem_align.sv | 46 ++++
 rtl/mem_bridge.sv | 113 +++++++++++
 tb/tb_mem_bridge.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_ops_pkg.sv
// Shared encodings for the core-to-bus memory bridge: op codes, FSM states,
// and the decoded access descriptor used by the bridge and its lane steering.
package mem_ops_pkg;

  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_LW   = 3'd1;
  localparam logic [2:0] RD_LH   = 3'd2;
  localparam logic [2:0] RD_LHU  = 3'd3;
  localparam logic [2:0] RD_LB   = 3'd4;
  localparam logic [2:0] RD_LBU  = 3'd5;

  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_SW   = 2'd1;
  localparam logic [1:0] WR_SH   = 2'd2;
  localparam logic [1:0] WR_SB   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_e;
  typedef enum logic [1:0] {K_NONE, K_LOAD, K_STORE} kind_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  typedef struct packed {
    kind_e kind;
    size_e size;
    logic  sext;
  } mem_op_t;

  // Stores win over loads; reserved read codes 6/7 fall through to word loads.
  function automatic mem_op_t decode_op(input logic [2:0] rd_op, input logic [1:0] wr_op);
    mem_op_t op;
    op.kind = K_NONE;
    op.size = SZ_WORD;
    op.sext = 1'b0;
    if (wr_op != WR_NONE) begin
      op.kind = K_STORE;
      case (wr_op)
        WR_SH:   op.size = SZ_HALF;
        WR_SB:   op.size = SZ_BYTE;
        default: op.size = SZ_WORD;
      endcase
    end else if (rd_op != RD_NONE) begin
      op.kind = K_LOAD;
      case (rd_op)
        RD_LH:   begin op.size = SZ_HALF; op.sext = 1'b1; end
        RD_LHU:  op.size = SZ_HALF;
        RD_LB:   begin op.size = SZ_BYTE; op.sext = 1'b1; end
        RD_LBU:  op.size = SZ_BYTE;
        default: op.size = SZ_WORD;
      endcase
    end
    return op;
  endfunction

  function automatic logic misaligned(input mem_op_t op, input logic [1:0] addr_lo);
    return (op.kind != K_NONE) &&
           (((op.size == SZ_WORD) && (addr_lo != 2'b00)) ||
            ((op.size == SZ_HALF) && addr_lo[0]));
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// Word-wide request/acknowledge system bus between the bridge and a slave.
interface mem_bridge_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, be, addr, wdata, input rdata, ack);
  modport slave  (input req, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data lane selection with sign/zero extension.
module mem_align
  import mem_ops_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = bus_rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = bus_rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    be        = 4'b1111;
    wdata_rep = wdata;
    load_data = bus_rdata;
    if (op.kind == K_STORE) begin
      case (op.size)
        SZ_BYTE: begin
          be        = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        SZ_HALF: begin
          be        = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
    case (op.size)
      SZ_BYTE: load_data = {{24{op.sext & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{op.sext & lane_h[15]}}, lane_h};
      default: load_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Bridges the core's single-strobe memory port onto one req/ack bus
// transaction, with misalignment detection and a bus-wait watchdog.
module mem_bridge
  import mem_ops_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_init,
  input  logic [2:0]  mem_read_op,
  input  logic [1:0]  mem_write_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_err,
  mem_bridge_if.master bus
);

  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e        state, nxt_state;
  mem_op_t       cur_op, op_q, sel_op;
  logic [1:0]    addr_lo_q, sel_lo;
  logic          err_q, cur_misaligned, to_hit;
  logic [CW-1:0] cnt;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata, al_load;

  assign cur_op         = decode_op(mem_read_op, mem_write_op);
  assign cur_misaligned = misaligned(cur_op, addr[1:0]);
  // Steering sees the live request while deciding, the latched one afterwards.
  assign sel_op = (state == ST_IDLE) ? cur_op : op_q;
  assign sel_lo = (state == ST_IDLE) ? addr[1:0] : addr_lo_q;
  assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  mem_align u_align (
    .op        (sel_op),
    .addr_lo   (sel_lo),
    .wdata     (wdata),
    .bus_rdata (bus.rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_data (al_load)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked block as an ordinary branch.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE: if (mem_init)
                 nxt_state = (cur_op.kind == K_NONE || cur_misaligned) ? ST_DONE : ST_BUS;
      ST_BUS:  if (bus.ack || to_hit) nxt_state = ST_DONE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req   = (state == ST_BUS);
    mem_ready = (state == ST_DONE);
    mem_err   = (state == ST_DONE) && err_q;
  end

  // NOTE: state-holding assignments are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata     <= '0;
      bus.we    <= 1'b0;
      bus.be    <= '0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      op_q      <= '0;
      addr_lo_q <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (mem_init) begin
          op_q      <= cur_op;
          addr_lo_q <= addr[1:0];
          err_q     <= cur_misaligned;
          cnt       <= '0;
          if (cur_misaligned) rdata <= '0;
          if (nxt_state == ST_BUS) begin
            bus.we    <= (cur_op.kind == K_STORE);
            bus.be    <= al_be;
            bus.addr  <= {addr[31:2], 2'b00};
            bus.wdata <= al_wdata;
          end
        end
        ST_BUS: begin
          if (bus.ack) begin
            if (op_q.kind == K_LOAD) rdata <= al_load;
          end else if (to_hit) begin
            rdata <= '0;
            err_q <= 1'b1;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: loads, stores, misalignment, no-op,
// watchdog abort, stray ack and mid-access reset.
module tb_mem_bridge;
  import mem_ops_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_init;
  logic [2:0]  mem_read_op;
  logic [1:0]  mem_write_op;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        mem_ready, mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bridge_if bus_if ();

  mem_bridge #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_init     (mem_init),
    .mem_read_op  (mem_read_op),
    .mem_write_op (mem_write_op),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .mem_ready    (mem_ready),
    .mem_err      (mem_err),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle mem_init; returns just after the edge that samples it (cycle 1).
  task automatic start(input logic [2:0] rd, input logic [1:0] wr,
                       input logic [31:0] a, input logic [31:0] d);
    mem_init     = 1'b1;
    mem_read_op  = rd;
    mem_write_op = wr;
    addr         = a;
    wdata        = d;
    tick();
    mem_init     = 1'b0;
    mem_read_op  = RD_NONE;
    mem_write_op = WR_NONE;
  endtask

  task automatic ack_cycle(input logic [31:0] data);
    bus_if.ack   = 1'b1;
    bus_if.rdata = data;
    tick();
    bus_if.ack   = 1'b0;
    bus_if.rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_init = 1'b0; mem_read_op = RD_NONE; mem_write_op = WR_NONE;
    addr = '0; wdata = '0; bus_if.ack = 1'b0; bus_if.rdata = '0;
    tick(); tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_err", {31'b0, mem_err}, 32'h0);
    check("rst_req", {31'b0, bus_if.req}, 32'h0);
    check("rst_be", {28'b0, bus_if.be}, 32'h0);
    check("rst_addr", bus_if.addr, 32'h0);
    reset = 1'b0;
    tick();

    // LB at 0x103: byte 3 of 0x80FF1234 is 0x80, sign-extended.
    start(RD_LB, WR_NONE, 32'h0000_0103, 32'h0);
    check("lb_req", {31'b0, bus_if.req}, 32'h1);
    check("lb_we", {31'b0, bus_if.we}, 32'h0);
    check("lb_addr", bus_if.addr, 32'h0000_0100);
    check("lb_be", {28'b0, bus_if.be}, 32'hF);
    check("lb_ready_c1", {31'b0, mem_ready}, 32'h0);
    ack_cycle(32'h80FF_1234);
    check("lb_ready_c2", {31'b0, mem_ready}, 32'h1);
    check("lb_err", {31'b0, mem_err}, 32'h0);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    check("lb_req_drop", {31'b0, bus_if.req}, 32'h0);
    tick();
    check("lb_ready_pulse", {31'b0, mem_ready}, 32'h0);

    start(RD_LHU, WR_NONE, 32'h0000_0202, 32'h0);
    ack_cycle(32'hBEEF_0000);
    check("lhu_rdata", rdata, 32'h0000_BEEF);
    tick();
    start(RD_LH, WR_NONE, 32'h0000_0202, 32'h0);
    ack_cycle(32'hBEEF_0000);
    check("lh_rdata", rdata, 32'hFFFF_BEEF);
    tick();

    // SB at 0x301: lane 1, data replicated; rdata keeps the last load.
    start(RD_NONE, WR_SB, 32'h0000_0301, 32'h0000_00A5);
    check("sb_we", {31'b0, bus_if.we}, 32'h1);
    check("sb_be", {28'b0, bus_if.be}, 32'h2);
    check("sb_wdata", bus_if.wdata, 32'hA5A5_A5A5);
    check("sb_addr", bus_if.addr, 32'h0000_0300);
    tick();
    check("sb_hold_req", {31'b0, bus_if.req}, 32'h1);
    check("sb_hold_be", {28'b0, bus_if.be}, 32'h2);
    check("sb_early_ready", {31'b0, mem_ready}, 32'h0);
    ack_cycle(32'h0);
    check("sb_ready", {31'b0, mem_ready}, 32'h1);
    check("sb_rdata_kept", rdata, 32'hFFFF_BEEF);
    tick();

    // Misaligned word load aborts immediately.
    start(RD_LW, WR_NONE, 32'h0000_0402, 32'h0);
    check("mis_req", {31'b0, bus_if.req}, 32'h0);
    check("mis_ready", {31'b0, mem_ready}, 32'h1);
    check("mis_err", {31'b0, mem_err}, 32'h1);
    check("mis_rdata", rdata, 32'h0);
    tick();

    start(RD_LW, WR_NONE, 32'h0000_0500, 32'h0);
    ack_cycle(32'h1234_5678);
    check("lw_rdata", rdata, 32'h1234_5678);
    tick();
    start(RD_NONE, WR_NONE, 32'h0000_0600, 32'h0);
    check("nop_req", {31'b0, bus_if.req}, 32'h0);
    check("nop_ready", {31'b0, mem_ready}, 32'h1);
    check("nop_err", {31'b0, mem_err}, 32'h0);
    check("nop_rdata", rdata, 32'h1234_5678);
    tick();

    // Watchdog: four BUS cycles with no ack, then abort.
    start(RD_LW, WR_NONE, 32'h0000_0700, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_c%0d", i + 1), {31'b0, bus_if.req}, 32'h1);
      check($sformatf("to_ready_c%0d", i + 1), {31'b0, mem_ready}, 32'h0);
      tick();
    end
    check("to_req_drop", {31'b0, bus_if.req}, 32'h0);
    check("to_ready", {31'b0, mem_ready}, 32'h1);
    check("to_err", {31'b0, mem_err}, 32'h1);
    check("to_rdata", rdata, 32'h0);
    tick();
    ack_cycle(32'hFFFF_FFFF);
    check("stray_ready", {31'b0, mem_ready}, 32'h0);
    check("stray_req", {31'b0, bus_if.req}, 32'h0);
    check("stray_rdata", rdata, 32'h0);

    // mem_init during BUS is ignored; the original access completes.
    start(RD_LBU, WR_NONE, 32'h0000_0801, 32'h0);
    mem_init = 1'b1; mem_read_op = RD_LW; addr = 32'h0000_0902;
    tick();
    mem_init = 1'b0; mem_read_op = RD_NONE;
    check("busy_addr", bus_if.addr, 32'h0000_0800);
    ack_cycle(32'h0000_9A00);
    check("busy_rdata", rdata, 32'h0000_009A);
    check("busy_err", {31'b0, mem_err}, 32'h0);
    tick();

    // Reset while the bus is waiting.
    start(RD_LW, WR_NONE, 32'h0000_0A00, 32'h0);
    check("rb_req", {31'b0, bus_if.req}, 32'h1);
    reset = 1'b1;
    tick();
    check("rb_req_drop", {31'b0, bus_if.req}, 32'h0);
    check("rb_ready", {31'b0, mem_ready}, 32'h0);
    check("rb_addr", bus_if.addr, 32'h0);
    check("rb_rdata", rdata, 32'h0);
    reset = 1'b0;
    tick();
    check("rb_ready_after", {31'b0, mem_ready}, 32'h0);

    start(RD_NONE, WR_SW, 32'h0000_0010, 32'hDEAD_BEEF);
    check("sw_be", {28'b0, bus_if.be}, 32'hF);
    check("sw_wdata", bus_if.wdata, 32'hDEAD_BEEF);
    check("sw_addr", bus_if.addr, 32'h0000_0010);
    check("sw_we", {31'b0, bus_if.we}, 32'h1);
    ack_cycle(32'h0);
    check("sw_ready", {31'b0, mem_ready}, 32'h1);
    check("sw_err", {31'b0, mem_err}, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
